bus_region_decode: RTL and testbench
====================================

# bus_region_decode

Registered, parametrised memory-map decoder for the SM83 system bus. It accepts one CPU bus request at a time and classifies the address into a one-hot region select with a region-relative offset. It inserts per-region wait states and returns a single-cycle acknowledge. It also owns the boot-ROM overlay latch, which is cleared by a write to 0xFF50, and it mirrors echo RAM onto WRAM.

## Interface
Parameters:
- WAIT_W, 4: width of each wait-state parameter and of the internal counter.
- BOOT_SIZE, 256: boot-ROM overlay size in bytes, starting at 0x0000; legal range 1..0x8000.
- ECHO_EN, 1: 1 maps 0xE000-0xFDFF onto WRAM; 0 treats that range as unmapped.
- WAIT_BOOT, WAIT_CART, WAIT_VRAM, WAIT_WRAM, WAIT_IO, WAIT_HRAM, all 0: wait states inserted per region; each value lies in 0..2^WAIT_W-1.

Ports (clock and reset first):
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request; level, held by requester until ack.
- we  in  1  write qualifier, sampled with req.
- addr  in  16  CPU byte address.
- wdata  in  8  write data; used only for the 0xFF50 check.
- sel  out  6  one-hot region select: [0] boot, [1] cart, [2] vram, [3] wram, [4] io, [5] hram.
- offset  out  16  address relative to the selected region base.
- busy  out  1  transaction in flight.
- ack  out  1  one-cycle completion pulse.
- unmapped_err  out  1  the in-flight address hits no region.
- boot_en  out  1  boot overlay active.

## Operation
- Region priority is evaluated on the accepted address:
  - If boot_en is 1 and addr < BOOT_SIZE: boot, offset = addr.
  - Else 0x0000-0x7FFF: cart, offset = addr.
  - 0x8000-0x9FFF: vram, offset = addr-0x8000.
  - 0xA000-0xBFFF: unmapped.
  - 0xC000-0xDFFF: wram, offset = addr-0xC000.
  - 0xE000-0xFDFF: wram with offset = addr-0xE000 if ECHO_EN, else unmapped.
  - 0xFE00-0xFEFF: unmapped.
  - 0xFF00-0xFF7F and 0xFFFF: io, offset = addr-0xFF00 (0xFFFF gives 0x00FF).
  - 0xFF80-0xFFFE: hram, offset = addr-0xFF80.
- Unmapped addresses: sel=0, offset=0, unmapped_err=1, zero wait states.
- Offsets are 16-bit unsigned subtraction; no range can underflow.
- FSM has three states: IDLE, WAIT, ACK.
  - IDLE with req=1: latch addr, we and wdata; register sel, offset and err; load the counter with the region's WAIT_x. Go to ACK if the value is 0, else WAIT.
  - WAIT: decrement the counter; move to ACK when the counter is 1 at the edge.
  - ACK: go to IDLE unconditionally.
- req is ignored outside IDLE; there is no queuing.
- Boot disable: an accepted write (we=1) to 0xFF50 with wdata≠0 clears boot_en on the edge that leaves ACK. The clear is sticky until rst.
  - wdata=0 has no effect.
  - The access itself still decodes as io, offset 0x0050.
- A write to the boot region while boot_en=1 decodes as boot; err stays 0.

## Timing
- Reset values: sel=0, offset=0, busy=0, ack=0, unmapped_err=0, boot_en=1, state IDLE, counter 0.
- A request is accepted at edge T, when the FSM is in IDLE and req=1.
  - From T+1: busy=1, and sel/offset/unmapped_err are stable until the ack cycle inclusive.
  - Region wait count W: ack=1 during cycle T+1+W only.
  - Latency from accept edge to ack cycle is 1+W.
- In the cycle after ack: busy=0, sel=0, offset=0, unmapped_err=0, state IDLE.
  - A still-high req is accepted at that edge as a new transaction.
  - Peak throughput is one transaction per 2+W cycles.
- boot_en reads 0 from the cycle after the ack of the qualifying 0xFF50 write. A request accepted at that same edge already sees boot_en=0.
- rst mid-transaction aborts it: no ack is issued, all outputs take reset values the next cycle, and boot_en returns to 1.
- rst has priority over req on the same edge.

## Test plan
- Default params, out of reset: req with addr=0x0042, we=0. Required: ack one cycle after accept; sel=000001, offset=0x0042.
- Boot disable sequence:
  - write 0xFF50 with wdata=0x00: boot_en stays 1.
  - write 0xFF50 with wdata=0x01: sel=010000, offset=0x0050; boot_en=0 after ack.
  - read 0x0042: sel=000010 (cart).
- Echo and WAIT_WRAM=3:
  - addr=0xE123: sel=001000, offset=0x0123, ack exactly 4 cycles after the accept edge, busy high for 4 cycles.
  - Repeat with ECHO_EN=0: unmapped_err=1, sel=0, ack after 1 cycle.
- Boundary sweep, each address must produce exactly one sel bit or the err flag:
  - 0x9FFF → vram, 0x1FFF.
  - 0xA000 → err.
  - 0xFEFF → err.
  - 0xFF7F → io, 0x007F.
  - 0xFF80 → hram, 0x0000.
  - 0xFFFE → hram, 0x007E.
  - 0xFFFF → io, 0x00FF.
- Reset mid-wait: WAIT_VRAM=5, addr=0x8000, assert rst at accept+2. Required: no ack ever pulses; outputs go to reset values; a prior boot_en=0 returns to 1.
- Back-to-back: req held high across two transactions, addr 0xC000 then 0xFF80. Required: exactly one idle cycle between acks; the second ack shows hram offset 0x0000.

Source files
------------

// File: rtl/bus_region_decode.sv
// SM83 bus memory-map decoder: one-hot region select, region offset,
// per-region wait states, single-cycle ack and the boot-ROM overlay latch.
module bus_region_decode #(
    parameter int WAIT_W    = 4,
    parameter int BOOT_SIZE = 256,
    parameter int ECHO_EN   = 1,
    parameter int WAIT_BOOT = 0,
    parameter int WAIT_CART = 0,
    parameter int WAIT_VRAM = 0,
    parameter int WAIT_WRAM = 0,
    parameter int WAIT_IO   = 0,
    parameter int WAIT_HRAM = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [5:0]  sel,
    output logic [15:0] offset,
    output logic        busy,
    output logic        ack,
    output logic        unmapped_err,
    output logic        boot_en
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [16:0]       BOOT_LIM = 17'(BOOT_SIZE);
    localparam bit                ECHO     = (ECHO_EN != 0);
    localparam logic [WAIT_W-1:0] W_BOOT   = WAIT_W'(WAIT_BOOT);
    localparam logic [WAIT_W-1:0] W_CART   = WAIT_W'(WAIT_CART);
    localparam logic [WAIT_W-1:0] W_VRAM   = WAIT_W'(WAIT_VRAM);
    localparam logic [WAIT_W-1:0] W_WRAM   = WAIT_W'(WAIT_WRAM);
    localparam logic [WAIT_W-1:0] W_IO     = WAIT_W'(WAIT_IO);
    localparam logic [WAIT_W-1:0] W_HRAM   = WAIT_W'(WAIT_HRAM);
    localparam logic [WAIT_W-1:0] W_ONE    = WAIT_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_cnt;
    logic [5:0]        r_sel;
    logic [15:0]       r_off;
    logic              r_err;
    logic              r_boot_en;
    logic              r_clr;

    logic [5:0]        w_sel;
    logic [15:0]       w_off;
    logic              w_err;
    logic [WAIT_W-1:0] w_wait;
    logic              w_ff50;

    // Priority decode: the boot overlay shadows the low cartridge range.
    always_comb begin
        w_sel  = '0;
        w_off  = '0;
        w_err  = 1'b0;
        w_wait = '0;
        if (r_boot_en && ({1'b0, addr} < BOOT_LIM)) begin
            w_sel  = 6'b000001;
            w_off  = addr;
            w_wait = W_BOOT;
        end else if (addr <= 16'h7FFF) begin
            w_sel  = 6'b000010;
            w_off  = addr;
            w_wait = W_CART;
        end else if (addr <= 16'h9FFF) begin
            w_sel  = 6'b000100;
            w_off  = addr - 16'h8000;
            w_wait = W_VRAM;
        end else if (addr <= 16'hBFFF) begin
            w_err  = 1'b1;
        end else if (addr <= 16'hDFFF) begin
            w_sel  = 6'b001000;
            w_off  = addr - 16'hC000;
            w_wait = W_WRAM;
        end else if (addr <= 16'hFDFF) begin
            if (ECHO) begin
                w_sel  = 6'b001000;
                w_off  = addr - 16'hE000;
                w_wait = W_WRAM;
            end else begin
                w_err  = 1'b1;
            end
        end else if (addr <= 16'hFEFF) begin
            w_err  = 1'b1;
        end else if ((addr <= 16'hFF7F) || (addr == 16'hFFFF)) begin
            w_sel  = 6'b010000;
            w_off  = addr - 16'hFF00;
            w_wait = W_IO;
        end else begin
            w_sel  = 6'b100000;
            w_off  = addr - 16'hFF80;
            w_wait = W_HRAM;
        end
    end

    assign w_ff50 = we && (addr == 16'hFF50) && (wdata != 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next = (w_wait == '0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == W_ONE) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Boot clear is deferred to the ACK exit so the FF50 access itself still decodes normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sel     <= '0;
            r_off     <= '0;
            r_err     <= 1'b0;
            r_boot_en <= 1'b1;
            r_clr     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_sel <= w_sel;
                        r_off <= w_off;
                        r_err <= w_err;
                        r_cnt <= w_wait;
                        r_clr <= w_ff50;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - W_ONE;
                end
                S_ACK: begin
                    r_sel <= '0;
                    r_off <= '0;
                    r_err <= 1'b0;
                    r_cnt <= '0;
                    r_clr <= 1'b0;
                    if (r_clr) begin
                        r_boot_en <= 1'b0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign sel          = r_sel;
    assign offset       = r_off;
    assign unmapped_err = r_err;
    assign boot_en      = r_boot_en;
    assign busy         = (r_state != S_IDLE);
    assign ack          = (r_state == S_ACK);

endmodule

// File: tb/tb_bus_region_decode.sv
// Bench for bus_region_decode: two parameter sets, directed sequences
// plus random traffic, compared every cycle against a transaction-level model.
module tb_bus_region_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i   [2];
    logic        we_i    [2];
    logic [15:0] addr_i  [2];
    logic [7:0]  wdata_i [2];
    logic [5:0]  sel_o   [2];
    logic [15:0] off_o   [2];
    logic        busy_o  [2];
    logic        ack_o   [2];
    logic        err_o   [2];
    logic        boot_o  [2];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: left = edges remaining until the ack cycle.
    int m_busy [2];
    int m_left [2];
    int m_sel  [2];
    int m_off  [2];
    int m_err  [2];
    int m_boot [2];
    int m_clr  [2];

    always #5 clk = ~clk;

    bus_region_decode #(
        .WAIT_W(4), .BOOT_SIZE(256), .ECHO_EN(1),
        .WAIT_BOOT(0), .WAIT_CART(0), .WAIT_VRAM(5),
        .WAIT_WRAM(3), .WAIT_IO(0), .WAIT_HRAM(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .req(req_i[0]), .we(we_i[0]),
        .addr(addr_i[0]), .wdata(wdata_i[0]), .sel(sel_o[0]),
        .offset(off_o[0]), .busy(busy_o[0]), .ack(ack_o[0]),
        .unmapped_err(err_o[0]), .boot_en(boot_o[0])
    );

    bus_region_decode #(
        .WAIT_W(4), .BOOT_SIZE(32768), .ECHO_EN(0),
        .WAIT_BOOT(2), .WAIT_CART(1), .WAIT_VRAM(0),
        .WAIT_WRAM(1), .WAIT_IO(2), .WAIT_HRAM(15)
    ) u_dut1 (
        .clk(clk), .rst(rst), .req(req_i[1]), .we(we_i[1]),
        .addr(addr_i[1]), .wdata(wdata_i[1]), .sel(sel_o[1]),
        .offset(off_o[1]), .busy(busy_o[1]), .ack(ack_o[1]),
        .unmapped_err(err_o[1]), .boot_en(boot_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory map from the address rules; region index 0..5, -1 = unmapped.
    function automatic void ref_decode(input int d, input int a, input int boot,
                                       output int s, output int o,
                                       output int e, output int w);
        int bsize;
        int echo;
        int wt [6];
        int r;
        bsize = (d == 0) ? 256 : 32768;
        echo  = (d == 0) ? 1 : 0;
        if (d == 0) wt = '{0, 0, 5, 3, 0, 0};
        else        wt = '{2, 1, 0, 1, 2, 15};
        r = -1;
        o = 0;
        if (boot != 0 && a < bsize) begin r = 0; o = a; end
        else if (a < 'h8000) begin r = 1; o = a; end
        else if (a < 'hA000) begin r = 2; o = a - 'h8000; end
        else if (a < 'hC000) r = -1;
        else if (a < 'hE000) begin r = 3; o = a - 'hC000; end
        else if (a < 'hFE00) begin
            if (echo != 0) begin r = 3; o = a - 'hE000; end
        end
        else if (a < 'hFF00) r = -1;
        else if (a < 'hFF80 || a == 'hFFFF) begin r = 4; o = a - 'hFF00; end
        else begin r = 5; o = a - 'hFF80; end
        if (r < 0) begin
            s = 0; o = 0; e = 1; w = 0;
        end else begin
            s = 1 << r; e = 0; w = wt[r];
        end
    endfunction

    task automatic model_tick(input int d);
        int s, o, e, w;
        if (rst) begin
            m_busy[d] = 0; m_left[d] = 0; m_sel[d] = 0;
            m_off[d] = 0; m_err[d] = 0; m_boot[d] = 1; m_clr[d] = 0;
        end else if (m_busy[d] != 0) begin
            if (m_left[d] == 0) begin
                m_busy[d] = 0; m_sel[d] = 0; m_off[d] = 0; m_err[d] = 0;
                if (m_clr[d] != 0) m_boot[d] = 0;
                m_clr[d] = 0;
            end else begin
                m_left[d]--;
            end
        end else if (req_i[d]) begin
            ref_decode(d, int'(addr_i[d]), m_boot[d], s, o, e, w);
            m_busy[d] = 1; m_left[d] = w;
            m_sel[d] = s; m_off[d] = o; m_err[d] = e;
            m_clr[d] = (we_i[d] && addr_i[d] == 16'hFF50 && wdata_i[d] != 8'h00) ? 1 : 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick(0);
        model_tick(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("m%0d_sel", d),  32'(sel_o[d]),  m_sel[d]);
            chk($sformatf("m%0d_off", d),  32'(off_o[d]),  m_off[d]);
            chk($sformatf("m%0d_err", d),  32'(err_o[d]),  m_err[d]);
            chk($sformatf("m%0d_busy", d), 32'(busy_o[d]), m_busy[d]);
            chk($sformatf("m%0d_ack", d),  32'(ack_o[d]),
                (m_busy[d] != 0 && m_left[d] == 0) ? 1 : 0);
            chk($sformatf("m%0d_boot", d), 32'(boot_o[d]), m_boot[d]);
        end
    endtask

    task automatic xact(input int d, input logic [15:0] a, input logic w,
                        input logic [7:0] wd, input logic [5:0] es,
                        input logic [15:0] eo, input logic ee, input int el);
        int  n;
        int  nb;
        bit  got;
        string t;
        n = 0; nb = 0; got = 0;
        t = $sformatf("x%0d_%04h", d, a);
        req_i[d] = 1'b1; we_i[d] = w; addr_i[d] = a; wdata_i[d] = wd;
        while (!got && n < 40) begin
            step();
            n++;
            if (busy_o[d]) nb++;
            if (ack_o[d]) begin
                got = 1;
                chk({t, "_sel"}, 32'(sel_o[d]), 32'(es));
                chk({t, "_off"}, 32'(off_o[d]), 32'(eo));
                chk({t, "_err"}, 32'(err_o[d]), 32'(ee));
            end
        end
        chk({t, "_lat"}, got ? n : -1, el);
        chk({t, "_busy_cyc"}, nb, el);
        req_i[d] = 1'b0; we_i[d] = 1'b0;
        step();
    endtask

    function automatic logic [15:0] pick_addr();
        logic [15:0] bl [16];
        bl = '{16'h0000, 16'h00FF, 16'h0100, 16'h7FFF, 16'h8000, 16'h9FFF,
               16'hA000, 16'hBFFF, 16'hC000, 16'hDFFF, 16'hE000, 16'hFDFF,
               16'hFE00, 16'hFF7F, 16'hFF80, 16'hFFFF};
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1: return bl[$urandom_range(0, 15)];
            2: return 16'hFF50;
            default: return 16'($urandom_range(0, 16'h02FF));
        endcase
    endfunction

    initial begin
        bit ack_seen;
        int k;
        for (int d = 0; d < 2; d++) begin
            req_i[d] = 1'b0; we_i[d] = 1'b0;
            addr_i[d] = '0; wdata_i[d] = '0;
        end
        rst = 1'b1;
        step();
        step();
        chk("rst_sel", 32'(sel_o[0]), 0);
        chk("rst_off", 32'(off_o[0]), 0);
        chk("rst_busy", 32'(busy_o[0]), 0);
        chk("rst_ack", 32'(ack_o[0]), 0);
        chk("rst_err", 32'(err_o[0]), 0);
        chk("rst_boot", 32'(boot_o[0]), 1);
        rst = 1'b0;
        step();

        xact(0, 16'h0042, 1'b0, 8'h00, 6'b000001, 16'h0042, 1'b0, 1);
        xact(0, 16'hFF50, 1'b1, 8'h00, 6'b010000, 16'h0050, 1'b0, 1);
        chk("ff50_zero_boot", 32'(boot_o[0]), 1);
        xact(0, 16'hFF50, 1'b1, 8'h01, 6'b010000, 16'h0050, 1'b0, 1);
        chk("ff50_one_boot", 32'(boot_o[0]), 0);
        xact(0, 16'h0042, 1'b0, 8'h00, 6'b000010, 16'h0042, 1'b0, 1);

        xact(0, 16'hE123, 1'b0, 8'h00, 6'b001000, 16'h0123, 1'b0, 4);
        xact(1, 16'hE123, 1'b0, 8'h00, 6'b000000, 16'h0000, 1'b1, 1);

        xact(0, 16'h9FFF, 1'b0, 8'h00, 6'b000100, 16'h1FFF, 1'b0, 6);
        xact(0, 16'hA000, 1'b0, 8'h00, 6'b000000, 16'h0000, 1'b1, 1);
        xact(0, 16'hFEFF, 1'b1, 8'h55, 6'b000000, 16'h0000, 1'b1, 1);
        xact(0, 16'hFF7F, 1'b0, 8'h00, 6'b010000, 16'h007F, 1'b0, 1);
        xact(0, 16'hFF80, 1'b0, 8'h00, 6'b100000, 16'h0000, 1'b0, 1);
        xact(0, 16'hFFFE, 1'b0, 8'h00, 6'b100000, 16'h007E, 1'b0, 1);
        xact(0, 16'hFFFF, 1'b0, 8'h00, 6'b010000, 16'h00FF, 1'b0, 1);
        xact(1, 16'h7FFF, 1'b1, 8'h12, 6'b000001, 16'h7FFF, 1'b0, 3);

        // Reset two edges after accept of a 5-wait VRAM access.
        ack_seen = 0;
        req_i[0] = 1'b1; addr_i[0] = 16'h8000; we_i[0] = 1'b0;
        step();
        ack_seen |= ack_o[0];
        step();
        ack_seen |= ack_o[0];
        rst = 1'b1; req_i[0] = 1'b0;
        step();
        ack_seen |= ack_o[0];
        chk("rstmid_busy", 32'(busy_o[0]), 0);
        chk("rstmid_sel", 32'(sel_o[0]), 0);
        chk("rstmid_off", 32'(off_o[0]), 0);
        chk("rstmid_boot", 32'(boot_o[0]), 1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            ack_seen |= ack_o[0];
        end
        chk("rstmid_no_ack", 32'(ack_seen), 0);

        // Back-to-back with req held high.
        req_i[0] = 1'b1; addr_i[0] = 16'hC000;
        k = 0;
        do begin
            step();
            k++;
        end while (!ack_o[0] && k < 40);
        chk("b2b_first_lat", k, 4);
        addr_i[0] = 16'hFF80;
        step();
        chk("b2b_gap_ack", 32'(ack_o[0]), 0);
        chk("b2b_gap_busy", 32'(busy_o[0]), 0);
        step();
        chk("b2b_second_ack", 32'(ack_o[0]), 1);
        chk("b2b_second_sel", 32'(sel_o[0]), 32'h20);
        chk("b2b_second_off", 32'(off_o[0]), 0);
        req_i[0] = 1'b0;
        step();

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int d = 0; d < 2; d++) begin
                req_i[d]   = ($urandom_range(0, 9) < 7);
                we_i[d]    = $urandom_range(0, 1) != 0;
                addr_i[d]  = pick_addr();
                wdata_i[d] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
